rr_arbiter: RTL and testbench

- Round-robin arbiter with a valid/ack grant handshake, for W requesters.
- Directly consumes the existing one-hot-to-unary `mask` block: the registered last-grant pointer drives mask, and the mask output splits requests into a higher-priority and a lower-priority set.
- Sits in front of any shared resource port (queue write, bus issue slot) where a single winner per cycle must be held stable until accepted.

---
 rtl/rr_arbiter_pkg.sv | 22 ++
 rtl/mask.sv | 33 +++
 rtl/pri_lsb.sv | 28 ++
 rtl/rr_arbiter.sv | 144 ++++++++++++++
 tb/tb_rr_arbiter.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/rr_arbiter_pkg.sv
// Shared helpers for the round-robin arbiter slice.
// Holds the widest supported requester count and a one-hot to binary encoder
// that any block of this family can reuse on a zero-extended vector.
package rr_arbiter_pkg;

    localparam int MAX_W     = 64;
    localparam int MAX_W_ENC = 6;

    // OR together the indices of all set bits; exact for one-hot inputs,
    // zero for an all-zero input.
    function automatic logic [MAX_W_ENC-1:0] onehot_to_bin(input logic [MAX_W-1:0] v);
        logic [MAX_W_ENC-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_W; i++) begin
            if (v[i]) begin
                r = r | i[MAX_W_ENC-1:0];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mask.sv
// One-hot to unary mask.
// TOWARDS_LSB=0 sets bits above the hot bit, TOWARDS_LSB=1 sets bits below it;
// INCLUSIVE additionally sets the hot bit itself. All-zero input gives zero.
module mask #(
    parameter int W           = 4,
    parameter bit TOWARDS_LSB = 1'b0,
    parameter bit INCLUSIVE   = 1'b0
) (
    input  logic [W-1:0] i_x,
    output logic [W-1:0] o_y
);

    // Sweep from the hot bit outwards, carrying a "seen" flag.
    always_comb begin
        logic seen;
        seen = 1'b0;
        o_y  = '0;
        if (!TOWARDS_LSB) begin
            for (int k = 0; k < W; k++) begin
                if (INCLUSIVE) seen = seen | i_x[k];
                o_y[k] = seen;
                if (!INCLUSIVE) seen = seen | i_x[k];
            end
        end else begin
            for (int k = W - 1; k >= 0; k--) begin
                if (INCLUSIVE) seen = seen | i_x[k];
                o_y[k] = seen;
                if (!INCLUSIVE) seen = seen | i_x[k];
            end
        end
    end

endmodule

// File: rtl/pri_lsb.sv
// Lowest-set-bit priority picker.
// Produces the one-hot winner, its binary index and a valid flag.
module pri_lsb #(
    parameter int W     = 4,
    parameter int W_ENC = (W > 1) ? $clog2(W) : 1
) (
    input  logic [W-1:0]     i_req,
    output logic [W-1:0]     o_gnt,
    output logic [W_ENC-1:0] o_enc,
    output logic             o_vld
);

    // Scan from the MSB down so the last hit overwriting the result is the lowest.
    always_comb begin
        o_gnt = '0;
        o_enc = '0;
        for (int k = W - 1; k >= 0; k--) begin
            if (i_req[k]) begin
                o_gnt    = '0;
                o_gnt[k] = 1'b1;
                o_enc    = k[W_ENC-1:0];
            end
        end
    end

    assign o_vld = |i_req;

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a valid/ack grant handshake.
//
// Handshake: o_gnt_vld=1 presents a grant; the grant is accepted in any cycle
// where o_gnt_vld && i_ack at the rising edge. An unaccepted grant is held
// bit-identical until accepted. i_ack with no grant presented is ignored.
//
// Priority rotates in ascending index order starting just above the last
// accepted winner, wrapping from W-1 to 0. After an accepted held grant the
// next arbitration happens one cycle later.
module rr_arbiter
    import rr_arbiter_pkg::*;
#(
    parameter int W     = 4,
    parameter int W_ENC = (W > 1) ? $clog2(W) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [W-1:0]     i_req,
    input  logic             i_ack,
    output logic [W-1:0]     o_gnt,
    output logic [W_ENC-1:0] o_gnt_enc,
    output logic             o_gnt_vld
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } st_e;

    st_e              st_q;
    logic [W-1:0]     last_q;
    logic [W-1:0]     hold_q;

    logic [W-1:0]     mask_y;
    logic [W-1:0]     req_hi;
    logic [W-1:0]     hi_gnt;
    logic [W_ENC-1:0] hi_enc;
    logic             hi_vld;
    logic [W-1:0]     lo_gnt;
    logic [W_ENC-1:0] lo_enc;
    logic             lo_vld;
    logic [W_ENC-1:0] hold_enc;
    logic [MAX_W_ENC-1:0] hold_enc_full;

    // Bits strictly above the last winner form the higher-priority window.
    mask #(
        .W           (W),
        .TOWARDS_LSB (1'b0),
        .INCLUSIVE   (1'b0)
    ) u_mask (
        .i_x (last_q),
        .o_y (mask_y)
    );

    assign req_hi = i_req & mask_y;

    pri_lsb #(
        .W     (W),
        .W_ENC (W_ENC)
    ) u_pri_hi (
        .i_req (req_hi),
        .o_gnt (hi_gnt),
        .o_enc (hi_enc),
        .o_vld (hi_vld)
    );

    pri_lsb #(
        .W     (W),
        .W_ENC (W_ENC)
    ) u_pri_lo (
        .i_req (i_req),
        .o_gnt (lo_gnt),
        .o_enc (lo_enc),
        .o_vld (lo_vld)
    );

    assign hold_enc_full = onehot_to_bin(MAX_W'(hold_q));
    assign hold_enc      = hold_enc_full[W_ENC-1:0];

    // Output select: forced zero in reset, held grant in HOLD, else the live pick.
    always_comb begin
        o_gnt     = '0;
        o_gnt_enc = '0;
        if (rst) begin
            o_gnt     = '0;
            o_gnt_enc = '0;
        end else if (st_q == HOLD) begin
            o_gnt     = hold_q;
            o_gnt_enc = hold_enc;
        end else if (hi_vld) begin
            o_gnt     = hi_gnt;
            o_gnt_enc = hi_enc;
        end else if (lo_vld) begin
            o_gnt     = lo_gnt;
            o_gnt_enc = lo_enc;
        end
    end

    assign o_gnt_vld = |o_gnt;

    // Grant FSM: commit the pointer on accept, latch the grant when unaccepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            st_q          <= IDLE;
            last_q        <= '0;
            last_q[W-1]   <= 1'b1;
            hold_q        <= '0;
        end else begin
            case (st_q)
                IDLE: begin
                    if (o_gnt_vld) begin
                        if (i_ack) begin
                            last_q <= o_gnt;
                        end else begin
                            hold_q <= o_gnt;
                            st_q   <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (i_ack) begin
                        last_q <= hold_q;
                        hold_q <= '0;
                        st_q   <= IDLE;
                    end
                end
                default: st_q <= IDLE;
            endcase
        end
    end

`ifndef SYNTHESIS
    a_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(o_gnt));
    a_vld:    assert property (@(posedge clk) disable iff (rst) o_gnt_vld == (|o_gnt));
    a_stable: assert property (@(posedge clk) disable iff (rst)
                               (o_gnt_vld && !i_ack) |=> $stable(o_gnt));
    a_idle:   assert property (@(posedge clk) disable iff (rst)
                               (st_q == IDLE) |-> ((o_gnt & ~i_req) == '0));
    // A held requester must keep its request up until acknowledged.
    a_proto:  assert property (@(posedge clk) disable iff (rst)
                               (st_q == HOLD) |-> ((i_req & hold_q) != '0));
`endif

endmodule

// File: tb/tb_rr_arbiter.sv
// Bench for rr_arbiter: W=4 instance with a reference model feeding a
// scoreboard, directed checks against literal expectations, a random soak
// with a fairness monitor, and a W=1 instance.
module tb_rr_arbiter;

    localparam int W  = 4;
    localparam int WE = 2;
    localparam int EW = 1 + WE + W;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  req;
    logic          ack;
    logic [W-1:0]  gnt;
    logic [WE-1:0] gnt_enc;
    logic          gnt_vld;

    logic          rst1;
    logic          req1;
    logic          ack1;
    logic          gnt1;
    logic          enc1;
    logic          vld1;

    int n_checks = 0;
    int n_errors = 0;

    logic [EW-1:0] exp_q[$];

    // reference model state
    int            m_last;
    logic          m_hold;
    logic [W-1:0]  m_hold_gnt;
    int            wait_cnt[W];

    logic [W-1:0]  obs_gnt;
    logic [WE-1:0] obs_enc;
    logic          obs_vld;

    // clock / reset
    always #5 clk = ~clk;

    rr_arbiter #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_req     (req),
        .i_ack     (ack),
        .o_gnt     (gnt),
        .o_gnt_enc (gnt_enc),
        .o_gnt_vld (gnt_vld)
    );

    rr_arbiter #(.W(1)) dut1 (
        .clk       (clk),
        .rst       (rst1),
        .i_req     (req1),
        .i_ack     (ack1),
        .o_gnt     (gnt1),
        .o_gnt_enc (enc1),
        .o_gnt_vld (vld1)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int idx_of(input logic [W-1:0] g);
        int r;
        r = 0;
        for (int i = 0; i < W; i++) if (g[i]) r = i;
        return r;
    endfunction

    // Search upward from the slot after the last winner, wrapping around.
    function automatic logic [W-1:0] model_pick(input logic [W-1:0] r, input int last);
        logic [W-1:0] g;
        int           j;
        g = '0;
        for (int s = 1; s <= W; s++) begin
            j = (last + s) % W;
            if (r[j] && g == '0) g[j] = 1'b1;
        end
        return g;
    endfunction

    function automatic logic [EW-1:0] model_expect(input logic [W-1:0] r, input logic rs);
        logic [W-1:0] g;
        logic [WE-1:0] e;
        if (rs) return '0;
        g = m_hold ? m_hold_gnt : model_pick(r, m_last);
        e = WE'(idx_of(g));
        return {(|g), e, g};
    endfunction

    task automatic model_update(input logic a, input logic rs, input logic [W-1:0] g, input logic [W-1:0] r);
        if (rs) begin
            m_last = W - 1;
            m_hold = 1'b0;
            for (int k = 0; k < W; k++) wait_cnt[k] = 0;
        end else begin
            // fairness monitor on accepted grants
            for (int k = 0; k < W; k++) if (!r[k]) wait_cnt[k] = 0;
            if (a && g != '0) begin
                for (int k = 0; k < W; k++) begin
                    if (g[k]) begin
                        wait_cnt[k] = 0;
                    end else if (r[k]) begin
                        wait_cnt[k]++;
                        check("fair", 64'(wait_cnt[k] > W - 1), 64'd0);
                    end
                end
            end
            if (m_hold) begin
                if (a) begin
                    m_last = idx_of(m_hold_gnt);
                    m_hold = 1'b0;
                end
            end else if (g != '0) begin
                if (a) begin
                    m_last = idx_of(g);
                end else begin
                    m_hold     = 1'b1;
                    m_hold_gnt = g;
                end
            end
        end
    endtask

    // driver: one cycle, inputs applied just after the edge, sampled mid-cycle
    task automatic step(input logic [W-1:0] r, input logic a, input logic rs);
        logic [EW-1:0] e;
        rst = rs;
        req = r;
        ack = a;
        e = model_expect(r, rs);
        exp_q.push_back(e);
        #4;
        obs_gnt = gnt;
        obs_enc = gnt_enc;
        obs_vld = gnt_vld;
        check("sb", {gnt_vld, gnt_enc, gnt}, exp_q.pop_front());
        model_update(a, rs, e[W-1:0], r);
        @(posedge clk);
        #1;
    endtask

    task automatic step1(input logic r, input logic a, input logic rs,
                         input logic eg, input string tag);
        rst1 = rs;
        req1 = r;
        ack1 = a;
        #4;
        check({tag, "_gnt"}, 64'(gnt1), 64'(eg));
        check({tag, "_vld"}, 64'(vld1), 64'(eg));
        check({tag, "_enc"}, 64'(enc1), 64'd0);
        @(posedge clk);
        #1;
    endtask

    logic [W-1:0]  t1_gnt[5];
    logic [WE-1:0] t1_enc[5];
    logic [W-1:0]  r;

    initial begin
        t1_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        t1_enc = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        m_last = W - 1;
        m_hold = 1'b0;
        m_hold_gnt = '0;
        for (int k = 0; k < W; k++) wait_cnt[k] = 0;
        rst = 1'b1; req = '0; ack = 1'b0;
        rst1 = 1'b1; req1 = 1'b0; ack1 = 1'b0;
        @(posedge clk);
        #1;

        // reset state, with requests and ack present
        step(4'b1111, 1'b1, 1'b1);
        check("rst_gnt", 64'(obs_gnt), 64'd0);
        check("rst_vld", 64'(obs_vld), 64'd0);
        step(4'b0000, 1'b0, 1'b1);

        // 1: rotation
        for (int i = 0; i < 5; i++) begin
            step(4'b1111, 1'b1, 1'b0);
            check("rot_gnt", 64'(obs_gnt), 64'(t1_gnt[i]));
            check("rot_enc", 64'(obs_enc), 64'(t1_enc[i]));
        end

        // 2: skip and wrap
        step(4'b0010, 1'b1, 1'b0);
        check("skip_setup", 64'(obs_gnt), 64'b0010);
        step(4'b1001, 1'b1, 1'b0);
        check("skip_gnt", 64'(obs_gnt), 64'b1000);
        step(4'b1001, 1'b1, 1'b0);
        check("wrap_gnt", 64'(obs_gnt), 64'b0001);
        step(4'b0000, 1'b1, 1'b0);
        check("none_vld", 64'(obs_vld), 64'd0);
        check("none_enc", 64'(obs_enc), 64'd0);

        // 3: hold with a toggling non-granted request
        step(4'b1000, 1'b1, 1'b0);
        check("hold_setup", 64'(obs_gnt), 64'b1000);
        step(4'b0011, 1'b0, 1'b0);
        check("hold_0", 64'(obs_gnt), 64'b0001);
        step(4'b0001, 1'b0, 1'b0);
        check("hold_1", 64'(obs_gnt), 64'b0001);
        step(4'b0011, 1'b0, 1'b0);
        check("hold_2", 64'(obs_gnt), 64'b0001);
        step(4'b0011, 1'b1, 1'b0);
        check("hold_acc", 64'(obs_gnt), 64'b0001);
        step(4'b0011, 1'b1, 1'b0);
        check("hold_next", 64'(obs_gnt), 64'b0010);

        // 4: reset while holding
        step(4'b0100, 1'b0, 1'b0);
        check("hrst_setup", 64'(obs_gnt), 64'b0100);
        step(4'b0100, 1'b1, 1'b1);
        check("hrst_gnt", 64'(obs_gnt), 64'd0);
        check("hrst_vld", 64'(obs_vld), 64'd0);
        step(4'b1111, 1'b1, 1'b0);
        check("hrst_after", 64'(obs_gnt), 64'b0001);

        // 5: random soak, keeping a held requester asserted
        for (int i = 0; i < 10000; i++) begin
            r = W'($urandom_range(0, (1 << W) - 1));
            if (m_hold) r = r | m_hold_gnt;
            step(r, 1'($urandom_range(0, 1)), 1'b0);
        end

        // 6: single requester build
        step1(1'b1, 1'b1, 1'b1, 1'b0, "w1_rst");
        step1(1'b1, 1'b0, 1'b0, 1'b1, "w1_g0");
        step1(1'b1, 1'b0, 1'b0, 1'b1, "w1_g1");
        step1(1'b1, 1'b1, 1'b0, 1'b1, "w1_acc");
        step1(1'b0, 1'b0, 1'b0, 1'b0, "w1_none");

        check("sb_drain", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
